// File: rtl/Qupls4_pkg.sv
// Qupls4_pkg: micro-op format and the opcode/func codes the trig issue queue decodes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package Qupls4_pkg;

    // Floating-point major opcodes: scalar H/S/D/Q, packed PH/PS/PD/PQ, and generic packed.
    localparam logic [6:0] OP_FLTH  = 7'h50;
    localparam logic [6:0] OP_FLTS  = 7'h51;
    localparam logic [6:0] OP_FLTD  = 7'h52;
    localparam logic [6:0] OP_FLTQ  = 7'h53;
    localparam logic [6:0] OP_FLTPH = 7'h54;
    localparam logic [6:0] OP_FLTPS = 7'h55;
    localparam logic [6:0] OP_FLTPD = 7'h56;
    localparam logic [6:0] OP_FLTPQ = 7'h57;
    localparam logic [6:0] OP_FLTP  = 7'h58;

    // Float sub-functions handled by the CORDIC unit.
    localparam logic [6:0] FLT_SIN  = 7'h10;
    localparam logic [6:0] FLT_COS  = 7'h11;
    localparam logic [6:0] FLT_ATAN = 7'h12;

    // Operation kind presented to the trig unit.
    localparam logic [1:0] KIND_SIN  = 2'd0;
    localparam logic [1:0] KIND_COS  = 2'd1;
    localparam logic [1:0] KIND_ATAN = 2'd2;

    typedef struct packed {
        logic [6:0] opcode;
        logic [6:0] func;
    } micro_op_t;

endpackage

// File: rtl/qupls4_trig_issue_queue.sv
// qupls4_trig_issue_queue: classifies LANES decoded micro-ops as trig, compacts them in lane order into a DEPTH-entry FIFO, issues one per cycle to the CORDIC unit.
// Latency: lane_trig is combinational; an accepted op reaches out_* the cycle after it is written (no empty-queue bypass).
// Backpressure: in_ready only when DEPTH-count >= LANES (all-or-nothing lane group); head holds stable while out_ready=0.
// Ports: clk, rst_n (sync, active low), flush; in_valid/in_uop/in_tag/in_ready lane group; lane_trig per-lane class;
//        out_valid/out_ready/out_kind/out_tag issue handshake; count = occupied entries.
module qupls4_trig_issue_queue
    import Qupls4_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int DEPTH   = 8,
    parameter int TAGW    = 6,
    parameter bit EN_SIN  = 1'b1,
    parameter bit EN_COS  = 1'b1,
    parameter bit EN_ATAN = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic [LANES-1:0]                in_valid,
    input  micro_op_t [LANES-1:0]           in_uop,
    input  logic [LANES-1:0][TAGW-1:0]      in_tag,
    output logic                            in_ready,
    output logic [LANES-1:0]                lane_trig,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [1:0]                      out_kind,
    output logic [TAGW-1:0]                 out_tag,
    output logic [$clog2(DEPTH+1)-1:0]      count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    // in_ready holds exactly when count is at or below this level.
    localparam logic [CW:0] READY_MAX_CNT = (CW+1)'(DEPTH - LANES);

    logic [1:0]      kind_mem [DEPTH];
    logic [TAGW-1:0] tag_mem  [DEPTH];

    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [1:0]      lane_kind [LANES];
    logic [PW-1:0]   lane_off  [LANES];
    logic [CW-1:0]   trig_cnt;
    logic            accept;
    logic            deq;

    function automatic logic is_flt_op(input logic [6:0] op);
        return op inside {OP_FLTH, OP_FLTS, OP_FLTD, OP_FLTQ,
                          OP_FLTPH, OP_FLTPS, OP_FLTPD, OP_FLTPQ, OP_FLTP};
    endfunction

    // Per-lane classification; a disabled function falls through as non-trig.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_trig[i] = 1'b0;
            lane_kind[i] = KIND_SIN;
            if (in_valid[i] && is_flt_op(in_uop[i].opcode)) begin
                case (in_uop[i].func)
                    FLT_SIN: begin
                        lane_trig[i] = EN_SIN;
                        lane_kind[i] = KIND_SIN;
                    end
                    FLT_COS: begin
                        lane_trig[i] = EN_COS;
                        lane_kind[i] = KIND_COS;
                    end
                    FLT_ATAN: begin
                        lane_trig[i] = EN_ATAN;
                        lane_kind[i] = KIND_ATAN;
                    end
                    default: begin
                        lane_trig[i] = 1'b0;
                        lane_kind[i] = KIND_SIN;
                    end
                endcase
            end
        end
    end

    // Compaction: each trig lane lands at wr_ptr + (number of trig lanes below it).
    always_comb begin
        trig_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_off[i] = PW'(trig_cnt);
            trig_cnt    = trig_cnt + CW'(lane_trig[i]);
        end
    end

    // Space check uses only the registered count so the ready path stays short;
    // a same-cycle dequeue does not open room early.
    assign in_ready  = ({1'b0, count} <= READY_MAX_CNT);
    assign accept    = in_ready & ~flush;
    assign out_valid = (count != '0);
    assign deq       = out_valid & out_ready;
    // Head is forced to zero while empty so stale entries never leak out.
    assign out_kind  = out_valid ? kind_mem[rd_ptr] : 2'd0;
    assign out_tag   = out_valid ? tag_mem[rd_ptr]  : '0;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(trig_cnt);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + (accept ? trig_cnt : '0) - CW'(deq);
        end
    end

    // Storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_trig[i]) begin
                    kind_mem[wr_ptr + lane_off[i]] <= lane_kind[i];
                    tag_mem[wr_ptr + lane_off[i]]  <= in_tag[i];
                end
            end
        end
    end

    count_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        count <= CW'(DEPTH));

    enq_fits: assert property (@(posedge clk) disable iff (!rst_n)
        accept |-> (({1'b0, count} + (CW+1)'(trig_cnt)) <= (CW+1)'(DEPTH)));

endmodule

// File: tb/tb_qupls4_trig_issue_queue.sv
// tb_qupls4_trig_issue_queue: scoreboard bench for the trig issue queue (default config plus an EN_COS=0 copy).
// Latency: n/a.
// Backpressure: randomised out_ready, flush and full-queue episodes.
module tb_qupls4_trig_issue_queue;
    import Qupls4_pkg::*;

    localparam int LANES = 4;
    localparam int DEPTH = 8;
    localparam int TAGW  = 6;
    localparam int CW    = $clog2(DEPTH+1);

    localparam logic [6:0] OP_ADD_NT = 7'h04;
    localparam logic [6:0] OP_LD_NT  = 7'h3F;
    localparam logic [6:0] FN_ADD    = 7'h00;
    localparam logic [6:0] FN_SQRT   = 7'h13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       rst_n;
    logic                       flush;
    logic                       out_ready;
    logic [LANES-1:0]           in_valid;
    micro_op_t [LANES-1:0]      in_uop;
    logic [LANES-1:0][TAGW-1:0] in_tag;

    wire                        in_ready,  in_ready_b;
    wire [LANES-1:0]            lane_trig, lane_trig_b;
    wire                        out_valid, out_valid_b;
    wire [1:0]                  out_kind,  out_kind_b;
    wire [TAGW-1:0]             out_tag,   out_tag_b;
    wire [CW-1:0]               count,     count_b;

    qupls4_trig_issue_queue #(.LANES(LANES), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_uop(in_uop),
        .in_tag(in_tag), .in_ready(in_ready), .lane_trig(lane_trig), .out_valid(out_valid),
        .out_ready(out_ready), .out_kind(out_kind), .out_tag(out_tag), .count(count));

    qupls4_trig_issue_queue #(.LANES(LANES), .DEPTH(DEPTH), .TAGW(TAGW), .EN_COS(1'b0)) dut_nocos (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_uop(in_uop),
        .in_tag(in_tag), .in_ready(in_ready_b), .lane_trig(lane_trig_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_kind(out_kind_b), .out_tag(out_tag_b), .count(count_b));

    // Reference model state.
    typedef struct {
        logic [1:0]      kind;
        logic [TAGW-1:0] tag;
    } ent_t;

    ent_t exp_q[$];       // expected contents of the full-featured queue, head first
    int   m2_count;       // expected occupancy of the EN_COS=0 queue
    bit   m_ready;
    bit   m2_ready;
    bit   chk_en;
    bit   chk_head_zero;
    int   checks   = 0;
    int   failures = 0;
    logic [6:0] flt_ops [9];

    // Kind (0 SIN, 1 COS, 2 ATAN) of a trig op, or -1 for anything else.
    function automatic int ref_kind(input micro_op_t u, input bit en_cos);
        if (!(u.opcode inside {OP_FLTH, OP_FLTS, OP_FLTD, OP_FLTQ,
                               OP_FLTPH, OP_FLTPS, OP_FLTPD, OP_FLTPQ, OP_FLTP}))
            return -1;
        if (u.func == FLT_SIN)  return 0;
        if (u.func == FLT_COS)  return en_cos ? 1 : -1;
        if (u.func == FLT_ATAN) return 2;
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: mid-cycle, compare DUT outputs against the model and retire transfers.
    initial begin : monitor
        logic [LANES-1:0] elt;
        logic [LANES-1:0] elt2;
        forever begin
            @(negedge clk);
            if (chk_en && rst_n === 1'b1) begin
                for (int i = 0; i < LANES; i++) begin
                    elt[i]  = in_valid[i] && (ref_kind(in_uop[i], 1'b1) >= 0);
                    elt2[i] = in_valid[i] && (ref_kind(in_uop[i], 1'b0) >= 0);
                end
                check("lane_trig", 32'(lane_trig), 32'(elt));
                check("count", 32'(count), exp_q.size());
                check("in_ready", 32'(in_ready), 32'((DEPTH - exp_q.size()) >= LANES));
                if (exp_q.size() > 0) begin
                    check("out_valid", 32'(out_valid), 1);
                    check("out_kind", 32'(out_kind), 32'(exp_q[0].kind));
                    check("out_tag", 32'(out_tag), 32'(exp_q[0].tag));
                    if (out_ready) void'(exp_q.pop_front());
                end else begin
                    check("out_valid", 32'(out_valid), 0);
                    if (chk_head_zero) begin
                        check("reset_out_kind", 32'(out_kind), 0);
                        check("reset_out_tag", 32'(out_tag), 0);
                    end
                end
                check("nocos_lane_trig", 32'(lane_trig_b), 32'(elt2));
                check("nocos_count", 32'(count_b), m2_count);
                check("nocos_in_ready", 32'(in_ready_b), 32'((DEPTH - m2_count) >= LANES));
                check("nocos_out_valid", 32'(out_valid_b), 32'(m2_count > 0));
            end
        end
    end

    // Advance one clock and apply to the model what the DUTs sampled at that edge.
    task automatic tick();
        int kk;
        int k2;
        @(posedge clk);
        if (!rst_n || flush) begin
            exp_q.delete();
            m2_count = 0;
        end else begin
            k2 = 0;
            for (int i = 0; i < LANES; i++) begin
                if (in_valid[i]) begin
                    kk = ref_kind(in_uop[i], 1'b1);
                    if (kk >= 0 && m_ready) begin
                        ent_t e;
                        e.kind = 2'(kk);
                        e.tag  = in_tag[i];
                        exp_q.push_back(e);
                    end
                    if (ref_kind(in_uop[i], 1'b0) >= 0) k2++;
                end
            end
            m2_count = m2_count + (m2_ready ? k2 : 0) - ((m2_count > 0 && out_ready) ? 1 : 0);
        end
        #1;
        m_ready  = (DEPTH - exp_q.size()) >= LANES;
        m2_ready = (DEPTH - m2_count) >= LANES;
    endtask

    task automatic set_lane(input int i, input logic v, input logic [6:0] op,
                            input logic [6:0] fn, input logic [TAGW-1:0] tg);
        in_valid[i]         = v;
        in_uop[i].opcode    = op;
        in_uop[i].func      = fn;
        in_tag[i]           = tg;
    endtask

    task automatic all_trig(input logic [TAGW-1:0] base);
        for (int i = 0; i < LANES; i++)
            set_lane(i, 1'b1, OP_FLTS, (i % 2 == 0) ? FLT_SIN : FLT_ATAN, TAGW'(base + TAGW'(i)));
    endtask

    task automatic drain();
        in_valid  = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH + 2) tick();
    endtask

    task automatic rand_lanes();
        for (int i = 0; i < LANES; i++) begin
            in_valid[i] = ($urandom_range(0, 99) < 75);
            if ($urandom_range(0, 99) < 70) in_uop[i].opcode = flt_ops[$urandom_range(0, 8)];
            else in_uop[i].opcode = ($urandom_range(0, 1) != 0) ? OP_ADD_NT : OP_LD_NT;
            case ($urandom_range(0, 4))
                0:       in_uop[i].func = FLT_SIN;
                1:       in_uop[i].func = FLT_COS;
                2:       in_uop[i].func = FLT_ATAN;
                3:       in_uop[i].func = FN_ADD;
                default: in_uop[i].func = FN_SQRT;
            endcase
            in_tag[i] = TAGW'($urandom);
        end
    endtask

    initial begin : stimulus
        flt_ops = '{OP_FLTH, OP_FLTS, OP_FLTD, OP_FLTQ, OP_FLTPH, OP_FLTPS, OP_FLTPD, OP_FLTPQ, OP_FLTP};
        chk_en        = 1'b0;
        chk_head_zero = 1'b0;
        m_ready       = 1'b1;
        m2_ready      = 1'b1;
        m2_count      = 0;
        rst_n         = 1'b0;
        flush         = 1'b0;
        out_ready     = 1'b0;
        in_valid      = '0;
        in_uop        = '0;
        in_tag        = '0;

        // T1: reset held two cycles with trig lanes presented.
        all_trig(6'd40);
        tick();
        tick();
        rst_n         = 1'b1;
        chk_en        = 1'b1;
        chk_head_zero = 1'b1;
        in_valid      = '0;
        tick();
        chk_head_zero = 1'b0;

        // T2: classify and compact {COS, ADD, SIN, ATAN} (lane3..lane0).
        drain();
        set_lane(0, 1'b1, OP_FLTD, FLT_ATAN, 6'd1);
        set_lane(1, 1'b1, OP_FLTD, FN_ADD,   6'd2);
        set_lane(2, 1'b1, OP_FLTD, FLT_SIN,  6'd3);
        set_lane(3, 1'b1, OP_FLTD, FLT_COS,  6'd4);
        out_ready = 1'b1;
        tick();
        in_valid = '0;
        repeat (4) tick();

        // T3: COS on OP_FLTS; the EN_COS=0 copy must ignore it.
        set_lane(0, 1'b1, OP_FLTS, FLT_COS, 6'd7);
        tick();
        in_valid = '0;
        repeat (3) tick();

        // T4: fill to full with the sink stalled, then release it.
        drain();
        out_ready = 1'b0;
        all_trig(6'd10);
        repeat (3) tick();
        repeat (2) tick();
        out_ready = 1'b1;
        repeat (8) tick();

        // T5: fresh pointers, fill 6, drain 5, then enqueue 4 while dequeuing across the wrap.
        in_valid = '0;
        rst_n    = 1'b0;
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b0;
        all_trig(6'd20);
        tick();
        all_trig(6'd24);
        in_valid[3:2] = 2'b00;
        tick();
        in_valid  = '0;
        out_ready = 1'b1;
        repeat (5) tick();
        all_trig(6'd30);
        tick();
        in_valid = '0;
        repeat (6) tick();

        // T6: flush with 5 queued, 2 trig lanes presented and a dequeue in flight.
        drain();
        out_ready = 1'b0;
        all_trig(6'd50);
        tick();
        all_trig(6'd54);
        in_valid[3:1] = 3'b000;
        tick();
        all_trig(6'd60);
        in_valid[3:2] = 2'b00;
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = '0;
        repeat (2) tick();

        // Random phase: upstream holds its lanes while the model says the queue is not ready.
        for (int c = 0; c < 1500; c++) begin
            if (m_ready || ($urandom_range(0, 99) < 5)) rand_lanes();
            out_ready = ($urandom_range(0, 99) < 65);
            flush     = ($urandom_range(0, 99) < 2);
            tick();
        end

        drain();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
